// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - snoops register-file writes to track a test run, console output and its verdict
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   we_i         register-file write enable (snooped)
//   waddr_i      register-file write address
//   wdata_i      register-file write data
//   con_ready_i  console sink accepts a character
//   con_valid_o  console character available
//   con_data_o   console character at the FIFO head
//   con_ovf_o    sticky flag, a console character was dropped
//   done_o       verdict reached (pass, fail or timeout)
//   pass_o       verdict: pass
//   fail_o       verdict: fail
//   timeout_o    verdict: timeout
//   testnum_o    last value written to NUM_REG
//   cycles_o     cycles spent in RUN, saturating
module test_monitor #(
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int NUM_REG        = 3,
  parameter int CON_REG        = 15,
  parameter int SETTLE_CYCLES  = 20,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        con_ready_i,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  output logic        con_ovf_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] testnum_o,
  output logic [31:0] cycles_o
);

  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TIMEOUT_U   = 32'(TIMEOUT_CYCLES);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_SETTLE,
    S_PASS,
    S_FAIL,
    S_TMO
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pass_shadow;
  logic [15:0] settle_cnt;
  logic [31:0] cycles_inc;
  logic [31:0] pass_eff;
  logic        terminal;

  logic        wr_q, wr_done, wr_pass, wr_num, wr_con;

  // x0 writes never reach the register file, so they are not snooped either
  assign wr_q    = we_i && (waddr_i != 5'd0);
  assign wr_done = wr_q && (waddr_i == 5'(DONE_REG)) && (wdata_i == 32'h1);
  assign wr_pass = wr_q && (waddr_i == 5'(PASS_REG));
  assign wr_num  = wr_q && (waddr_i == 5'(NUM_REG));
  assign wr_con  = wr_q && (waddr_i == 5'(CON_REG));

  assign terminal   = (state == S_PASS) || (state == S_FAIL) || (state == S_TMO);
  assign cycles_inc = (cycles_o == 32'hFFFF_FFFF) ? cycles_o : cycles_o + 32'd1;
  // a pass-flag write landing on the last settle cycle still counts
  assign pass_eff   = wr_pass ? wdata_i : pass_shadow;

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        // done write wins over a timeout reached in the same cycle
        if (wr_done)
          state_nxt = S_SETTLE;
        else if (cycles_inc >= TIMEOUT_U)
          state_nxt = S_TMO;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST)
          state_nxt = (pass_eff == 32'h1) ? S_PASS : S_FAIL;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pass_shadow <= 32'd0;
      settle_cnt  <= 16'd0;
      testnum_o   <= 32'd0;
      cycles_o    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_RUN)
        cycles_o <= cycles_inc;
      if (state == S_SETTLE)
        settle_cnt <= settle_cnt + 16'd1;
      else
        settle_cnt <= 16'd0;
      if (!terminal) begin
        if (wr_pass)
          pass_shadow <= wdata_i;
        if (wr_num)
          testnum_o <= wdata_i;
      end
    end
  end

  assign pass_o    = (state == S_PASS);
  assign fail_o    = (state == S_FAIL);
  assign timeout_o = (state == S_TMO);
  assign done_o    = pass_o | fail_o | timeout_o;

  // Console FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wptr, rptr;
  logic        fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign pop        = !fifo_empty && con_ready_i;
  // a full FIFO still takes a character when the head leaves in the same cycle
  assign push       = wr_con && (!fifo_full || pop);

  assign con_valid_o = !fifo_empty;
  assign con_data_o  = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      con_ovf_o <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (wr_con && !push)
        con_ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wptr[PW-1:0]] <= wdata_i[7:0];
  end

endmodule

// File: tb/tb_test_monitor.sv
// tb/tb_test_monitor.sv - scoreboard bench for test_monitor
module tb_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        con_ready_i;
  logic        con_valid_o;
  logic [7:0]  con_data_o;
  logic        con_ovf_o;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [31:0] testnum_o, cycles_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic [31:0] num;
    logic [31:0] cyc;
  } verdict_t;

  verdict_t    vq[$];
  logic [7:0]  cq[$];
  logic        done_prev = 1'b0;

  test_monitor #(
    .SETTLE_CYCLES (20),
    .TIMEOUT_CYCLES(50),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .con_ready_i(con_ready_i),
    .con_valid_o(con_valid_o),
    .con_data_o (con_data_o),
    .con_ovf_o  (con_ovf_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .timeout_o  (timeout_o),
    .testnum_o  (testnum_o),
    .cycles_o   (cycles_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares console handshakes and verdicts against the queues
  always @(negedge clk) begin
    verdict_t v;
    logic [7:0] c;
    if (con_valid_o && con_ready_i) begin
      if (cq.size() == 0) begin
        chk("con_unexpected", 32'(con_data_o), 32'hFFFF_FFFF);
      end else begin
        c = cq.pop_front();
        chk("con_data", 32'(con_data_o), 32'(c));
      end
    end
    if (done_o && !done_prev) begin
      if (vq.size() == 0) begin
        chk("verdict_unexpected", 32'(done_o), 32'd0);
      end else begin
        v = vq.pop_front();
        chk("verdict_pass", 32'(pass_o), 32'(v.p));
        chk("verdict_fail", 32'(fail_o), 32'(v.f));
        chk("verdict_tmo", 32'(timeout_o), 32'(v.t));
        chk("verdict_testnum", testnum_o, v.num);
        chk("verdict_cycles", cycles_o, v.cyc);
      end
    end
    done_prev = done_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i    = 1'b1;
    waddr_i = a;
    wdata_i = d;
    tick();
    we_i    = 1'b0;
    waddr_i = 5'd0;
    wdata_i = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_v(input logic p, input logic f, input logic t,
                        input logic [31:0] num, input logic [31:0] cyc);
    verdict_t v;
    v.p = p; v.f = f; v.t = t; v.num = num; v.cyc = cyc;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0; con_ready_i = 1'b0;

    // reset state, with a write presented during reset that must be ignored
    we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'd5;
    tick();
    tick();
    we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0;
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_valid", 32'(con_valid_o), 32'd0);
    chk("rst_ovf", 32'(con_ovf_o), 32'd0);
    chk("rst_testnum", testnum_o, 32'd0);
    chk("rst_cycles", cycles_o, 32'd0);
    rst = 1'b0;

    // pass
    push_v(1'b1, 1'b0, 1'b0, 32'd0, 32'd2);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    repeat (19) tick();
    chk("pass_early", 32'(pass_o), 32'd0);
    tick();
    chk("pass_o", 32'(pass_o), 32'd1);
    chk("pass_done", 32'(done_o), 32'd1);
    chk("pass_fail_o", 32'(fail_o), 32'd0);

    // fail, then writes after the verdict must not change anything
    do_reset();
    push_v(1'b0, 1'b1, 1'b0, 32'd7, 32'd3);
    wr(5'd3, 32'd7);
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    repeat (20) tick();
    chk("fail_o", 32'(fail_o), 32'd1);
    wr(5'd3, 32'd9);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    chk("fail_frozen_num", testnum_o, 32'd7);
    chk("fail_frozen_pass", 32'(pass_o), 32'd0);
    chk("fail_frozen_cyc", cycles_o, 32'd3);

    // pass flag written on the final settle cycle
    do_reset();
    push_v(1'b1, 1'b0, 1'b0, 32'd0, 32'd2);
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    repeat (19) tick();
    wr(5'd27, 32'd1);
    chk("late_pass", 32'(pass_o), 32'd1);

    // timeout; a non-1 done write is ignored
    do_reset();
    push_v(1'b0, 1'b0, 1'b1, 32'd0, 32'd50);
    wr(5'd26, 32'd2);
    repeat (48) tick();
    chk("tmo_early", 32'(timeout_o), 32'd0);
    tick();
    chk("tmo_o", 32'(timeout_o), 32'd1);
    chk("tmo_cycles", cycles_o, 32'd50);
    repeat (3) tick();
    chk("tmo_cycles_frozen", cycles_o, 32'd50);

    // done write in the same cycle as timeout goes to settle
    do_reset();
    push_v(1'b0, 1'b1, 1'b0, 32'd0, 32'd50);
    repeat (49) tick();
    wr(5'd26, 32'd1);
    chk("race_no_tmo", 32'(timeout_o), 32'd0);
    chk("race_cycles", cycles_o, 32'd50);
    repeat (20) tick();
    chk("race_fail", 32'(fail_o), 32'd1);

    // console "Hi"
    do_reset();
    con_ready_i = 1'b1;
    chk("con_idle", 32'(con_valid_o), 32'd0);
    cq.push_back(8'h48);
    wr(5'd15, 32'h48);
    chk("con_lat_valid", 32'(con_valid_o), 32'd1);
    chk("con_lat_data", 32'(con_data_o), 32'h48);
    cq.push_back(8'h69);
    wr(5'd15, 32'h69);
    chk("con_second", 32'(con_data_o), 32'h69);
    tick();
    chk("con_drained", 32'(con_valid_o), 32'd0);
    chk("con_no_ovf", 32'(con_ovf_o), 32'd0);

    // overflow on depth 4, then push+pop on full
    do_reset();
    con_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cq.push_back(8'h61 + 8'(i));
      wr(5'd15, 32'h61 + 32'(i));
    end
    chk("full_no_ovf", 32'(con_ovf_o), 32'd0);
    wr(5'd15, 32'h65);
    chk("ovf_set", 32'(con_ovf_o), 32'd1);
    chk("ovf_head", 32'(con_data_o), 32'h61);
    con_ready_i = 1'b1;
    cq.push_back(8'h66);
    wr(5'd15, 32'h66);
    repeat (4) tick();
    chk("ovf_drained", 32'(con_valid_o), 32'd0);
    chk("ovf_sticky", 32'(con_ovf_o), 32'd1);
    con_ready_i = 1'b0;

    // reset mid-settle with FIFO non-empty, then a normal pass
    do_reset();
    wr(5'd15, 32'h78);
    wr(5'd15, 32'h79);
    wr(5'd3, 32'd4);
    wr(5'd26, 32'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(con_valid_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_testnum", testnum_o, 32'd0);
    chk("mid_rst_cycles", cycles_o, 32'd0);
    rst = 1'b0;
    push_v(1'b1, 1'b0, 1'b0, 32'd0, 32'd2);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    repeat (20) tick();
    chk("after_rst_pass", 32'(pass_o), 32'd1);

    tick();
    chk("verdict_queue_empty", 32'(vq.size()), 32'd0);
    chk("con_queue_empty", 32'(cq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter DONE_REG, default 26, meaning register index whose write of 1 signals test end.
REQ-002 SHALL have parameter PASS_REG, default 27, meaning register index holding pass flag (1 = pass).
REQ-003 SHALL have parameter NUM_REG, default 3, meaning register index holding current test number.
REQ-004 SHALL have parameter CON_REG, default 15, meaning register index whose writes are console characters.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 20, meaning cycles waited after done before verdict (1..65535).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning cycles in RUN before timeout (>= 1).
REQ-007 SHALL have parameter FIFO_DEPTH, default 16, meaning console FIFO entries (power of two, >= 2).
REQ-008 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-009 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-010 SHALL have ports: we_i  in  1  register-file write enable (snooped).
REQ-011 SHALL have ports: waddr_i  in  5  register-file write address.
REQ-012 SHALL have ports: wdata_i  in  32  register-file write data.
REQ-013 SHALL have ports: con_ready_i  in  1  console sink accepts a character.
REQ-014 SHALL have ports: con_valid_o  out  1  console character available.
REQ-015 SHALL have ports: con_data_o  out  8  console character (FIFO head).
REQ-016 SHALL have ports: con_ovf_o  out  1  sticky, console character dropped.
REQ-017 SHALL have ports: done_o  out  1  verdict reached (PASS, FAIL or TMO).
REQ-018 SHALL have ports: pass_o / fail_o / timeout_o  out  1 each  one-hot verdict.
REQ-019 SHALL have ports: testnum_o  out  32  last value written to NUM_REG.
REQ-020 SHALL have ports: cycles_o  out  32  cycles spent in RUN, saturating at 2^32-1.

Function
REQ-021 SHALL implement states RUN, SETTLE, PASS, FAIL, TMO; PASS/FAIL/TMO terminal until rst.
REQ-022 SHALL ignore writes with waddr_i = 0 and all writes when we_i = 0.
REQ-023 SHALL shadow PASS_REG and NUM_REG data on every qualifying write, in all states, until terminal state.
REQ-024 SHALL leave RUN for SETTLE on the cycle after a write to DONE_REG with wdata_i = 32'h1; other DONE_REG values ignored.
REQ-025 SHALL count SETTLE_CYCLES cycles in SETTLE, then enter PASS if pass shadow = 32'h1, else FAIL.
REQ-026 SHALL use the pass shadow including a PASS_REG write made on the final SETTLE cycle.
REQ-027 SHALL increment cycles_o each RUN cycle; enter TMO when cycles_o reaches TIMEOUT_CYCLES in RUN.
REQ-028 SHALL give the done write priority when done write and timeout occur in the same cycle.
REQ-029 SHALL freeze testnum_o, cycles_o and shadows on entry to a terminal state.
REQ-030 SHALL push wdata_i[7:0] into the console FIFO on each qualifying CON_REG write, in any state.
REQ-031 SHALL present a pushed character on con_valid_o/con_data_o no earlier than the next cycle (1-cycle latency when empty).
REQ-032 SHALL pop when con_valid_o and con_ready_i are both high; head holds stable while con_ready_i low.
REQ-033 SHALL accept a push on a full FIFO only if a pop occurs the same cycle; otherwise drop it and set con_ovf_o.
REQ-034 SHALL never pop when empty; simultaneous push and pop on empty performs only the push.
REQ-035 SHALL wrap read/write pointers modulo FIFO_DEPTH, using an extra pointer bit for full/empty.
REQ-036 SHALL drive pass_o, fail_o, timeout_o mutually exclusive; done_o = OR of them.

Reset
REQ-037 SHALL on rst (any state, mid-settle or mid-FIFO) set state RUN, counters, shadows, testnum_o, cycles_o to 0.
REQ-038 SHALL on rst empty the FIFO, clear con_ovf_o, and drive con_valid_o, done_o, pass_o, fail_o, timeout_o to 0.
REQ-039 SHALL ignore we_i during any cycle rst is high.

Verification
REQ-040 SHALL cover pass: write x27=1, then x26=1 -> after SETTLE_CYCLES+1 cycles pass_o=1, done_o=1, fail_o=0.
REQ-041 SHALL cover fail: write x3=7, x27=0, x26=1 -> fail_o=1, testnum_o=7 after settle; later writes do not change outputs.
REQ-042 SHALL cover timeout: TIMEOUT_CYCLES=50, no done write -> timeout_o=1 at cycle 50, cycles_o=50; done write same cycle -> SETTLE instead.
REQ-043 SHALL cover console: write x15 = "H","i" with con_ready_i=1 -> con_data_o 8'h48 then 8'h69, one per cycle, con_ovf_o=0.
REQ-044 SHALL cover overflow: FIFO_DEPTH=4, con_ready_i=0, 5 writes to x15 -> 4 stored, con_ovf_o=1; push+pop on full -> accepted.
REQ-045 SHALL cover reset mid-SETTLE and with FIFO non-empty -> all outputs 0 next cycle, new test then passes normally.
